// File: rtl/sram_port_ctrl.sv
// Request-bus to asynchronous SRAM controller with a setup/strobe/hold access sequence.
// Optional one-entry read cache enabled by defining SRAM_PORT_CTRL_RDCACHE_EN.
module sram_port_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 48,
    parameter int BANKS       = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [BANKS-1:0]  sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_i,
    output logic [2:0]        dbg_state
);

    localparam int BW    = $clog2(BANKS);
    localparam int BI_W  = (BW > 0) ? BW : 1;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_port_ctrl: WAIT_CYCLES must be >= 1");
    end

    // Handshake: a request is accepted on the rising edge where req && ready;
    // the requester keeps req asserted until it observes ready, nothing is queued.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_HIT    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                accept;
    logic                hit;
    logic [DATA_W-1:0]   hit_data;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic                in_cycle;

    // Bank is taken from the top address bits; with one bank the shift clears the index.
    function automatic logic [BANKS-1:0] ce_decode(input logic [ADDR_W-1:0] a);
        logic [BI_W-1:0] b;
        b = BI_W'(a >> (ADDR_W - BW));
        return ~(BANKS'(1) << b);
    endfunction

    assign ready     = (state_q == S_IDLE) && !rst;
    assign accept    = (state_q == S_IDLE) && req;
    assign dbg_state = state_q;

    // Operation attributes of the access being set up this edge or already in flight.
    assign cur_we   = (state_q == S_IDLE) ? we   : we_q;
    assign cur_addr = (state_q == S_IDLE) ? addr : addr_q;
    assign in_cycle = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (req) state_d = hit ? S_HIT : S_SETUP;
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            S_ACCESS: begin
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_HOLD:   state_d = S_IDLE;
            S_HIT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_ce_n <= '1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            dq_o      <= '0;
            dq_oe     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done      <= (state_d == S_HOLD) || (state_d == S_HIT);
            sram_ce_n <= in_cycle ? ce_decode(cur_addr) : '1;
            sram_oe_n <= !(((state_d == S_SETUP) || (state_d == S_ACCESS)) && !cur_we);
            sram_we_n <= !((state_d == S_ACCESS) && cur_we);
            dq_oe     <= in_cycle && cur_we;
            if (accept) begin
                we_q   <= we;
                addr_q <= addr;
            end
            if (accept && !hit) sram_addr <= addr;
            if (accept && we)   dq_o      <= wdata;
            if ((state_q == S_ACCESS) && (cnt_q == '0) && !we_q) rdata <= dq_i;
            else if (state_d == S_HIT)                            rdata <= hit_data;
        end
    end

`ifdef SRAM_PORT_CTRL_RDCACHE_EN
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_tag;
    logic [DATA_W-1:0] cache_data;

    assign hit      = cache_valid && !we && (cache_tag == addr);
    assign hit_data = cache_data;

    // Read misses fill the entry; writes only refresh it when they hit the tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (state_q == S_HOLD) begin
            if (!we_q) begin
                cache_valid <= 1'b1;
                cache_tag   <= addr_q;
                cache_data  <= rdata;
            end else if (cache_valid && (cache_tag == addr_q)) begin
                cache_data  <= dq_o;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

endmodule
